// File: rtl/simmem_pkg.sv
// Shared simmem types and constants: write-address format, response-bank sizing,
// DRAM row/cost model parameters and the delay-calculator queue entry.
package simmem_pkg;

    localparam int AxIdWidth    = 4;
    localparam int AxAddrWidth  = 20;
    localparam int AxLenWidth   = 3;
    localparam int AxSizeWidth  = 3;
    localparam int AxBurstWidth = 2;

    localparam int NumWSlots     = 6;
    localparam int WRspBankCapa  = 8;
    localparam int WRspBankAddrW = $clog2(WRspBankCapa);

    localparam int RowIdWidth     = 10;
    localparam int RowHitCost     = 4;
    localparam int PrechargeCost  = 2;
    localparam int ActivationCost = 1;
    localparam int DelayW         = 7;

    typedef logic [WRspBankAddrW-1:0] write_iid_t;
    typedef logic [RowIdWidth-1:0]    row_id_t;
    typedef logic [AxLenWidth-1:0]    burst_len_t;

    typedef struct packed {
        logic [AxIdWidth-1:0]    id;
        logic [AxAddrWidth-1:0]  addr;
        burst_len_t              burst_len;
        logic [AxSizeWidth-1:0]  burst_size;
        logic [AxBurstWidth-1:0] burst_type;
    } waddr_t;

    typedef struct packed {
        row_id_t    row_id;
        burst_len_t burst_len;
        write_iid_t iid;
    } wrsp_delay_entry_t;

    typedef enum logic {
        DC_IDLE,
        DC_SERVICE
    } delay_calc_state_e;

    // The burst_len field encodes the beat count as a power of two.
    function automatic int unsigned get_effective_burst_len(input burst_len_t len);
        return 32'd1 << len;
    endfunction

endpackage

// File: rtl/simmem_delay_fifo.sv
// Circular FIFO of pending delay-calculator entries; depth need not be a power of two.
module simmem_delay_fifo
    import simmem_pkg::*;
#(
    parameter int Depth = NumWSlots
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  wrsp_delay_entry_t data_i,
    input  logic              pop_i,
    output wrsp_delay_entry_t data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    wrsp_delay_entry_t r_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/simmem_wrsp_delay_calc.sv
// Write-response delay calculator: single-bank open-row timing model releasing B responses.
// Optional row hit/miss counters under SIMMEM_DELAY_CALC_STATS_EN.
//   state      | meaning
//   DC_IDLE    | waiting for a queued burst; loads the head cost when one is present
//   DC_SERVICE | counting down the current burst; releases its iid when the count hits 1
module simmem_wrsp_delay_calc
    import simmem_pkg::*;
#(
    parameter int NumSlots = NumWSlots,
    parameter int BankCapa = WRspBankCapa
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  waddr_t                   waddr_i,
    input  logic [WRspBankAddrW-1:0] waddr_iid_i,
    input  logic                     waddr_valid_i,
    output logic                     waddr_ready_o,
    output logic [BankCapa-1:0]      release_en_o,
    output logic                     busy_o
`ifdef SIMMEM_DELAY_CALC_STATS_EN
    ,
    output logic [15:0]              row_hits_o,
    output logic [15:0]              row_misses_o
`endif
);

    delay_calc_state_e r_state, w_state_nxt;
    logic [DelayW-1:0] r_count, w_count_nxt;
    write_iid_t        r_iid, w_iid_nxt;
    row_id_t           r_open_row, w_open_row_nxt;
    logic              r_row_valid, w_row_valid_nxt;
    logic [BankCapa-1:0] r_release, w_release_nxt;

    wrsp_delay_entry_t w_push_entry;
    wrsp_delay_entry_t w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_row_hit;
    logic [DelayW:0]   w_row_cost;
    logic [DelayW:0]   w_total_cost;
    logic [DelayW-1:0] w_cost;
    logic              w_unused;

    assign w_push = waddr_valid_i && !w_full;

    always_comb begin
        w_push_entry           = '0;
        w_push_entry.row_id    = waddr_i.addr[AxAddrWidth-1 -: RowIdWidth];
        w_push_entry.burst_len = waddr_i.burst_len;
        w_push_entry.iid       = waddr_iid_i;
    end

    assign w_unused = ^{waddr_i.id, waddr_i.addr[AxAddrWidth-RowIdWidth-1:0],
                        waddr_i.burst_size, waddr_i.burst_type};

    simmem_delay_fifo #(
        .Depth (NumSlots)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Cost is evaluated one bit wider than the counter so saturation catches the overflow.
    assign w_row_hit = r_row_valid && (w_head.row_id == r_open_row);

    always_comb begin
        if (w_row_hit)
            w_row_cost = (DelayW+1)'(RowHitCost);
        else if (r_row_valid)
            w_row_cost = (DelayW+1)'(PrechargeCost + ActivationCost + RowHitCost);
        else
            w_row_cost = (DelayW+1)'(ActivationCost + RowHitCost);
        w_total_cost = w_row_cost
                     + (DelayW+1)'(get_effective_burst_len(w_head.burst_len) - 32'd1);
        w_cost = w_total_cost[DelayW] ? '1 : w_total_cost[DelayW-1:0];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_iid_nxt       = r_iid;
        w_open_row_nxt  = r_open_row;
        w_row_valid_nxt = r_row_valid;
        w_release_nxt   = '0;
        w_pop           = 1'b0;
        case (r_state)
            DC_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_count_nxt     = w_cost;
                    w_iid_nxt       = w_head.iid;
                    w_open_row_nxt  = w_head.row_id;
                    w_row_valid_nxt = 1'b1;
                    w_state_nxt     = DC_SERVICE;
                end
            end
            DC_SERVICE: begin
                w_count_nxt = r_count - DelayW'(1);
                if (r_count == DelayW'(1)) begin
                    for (int i = 0; i < BankCapa; i++)
                        w_release_nxt[i] = (int'(r_iid) == i);
                    w_state_nxt = DC_IDLE;
                end
            end
            default: w_state_nxt = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= DC_IDLE;
            r_count     <= '0;
            r_iid       <= '0;
            r_open_row  <= '0;
            r_row_valid <= 1'b0;
            r_release   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_iid       <= w_iid_nxt;
            r_open_row  <= w_open_row_nxt;
            r_row_valid <= w_row_valid_nxt;
            r_release   <= w_release_nxt;
        end
    end

    assign waddr_ready_o = !w_full;
    assign release_en_o  = r_release;
    assign busy_o        = (r_state == DC_SERVICE) || !w_empty;

`ifdef SIMMEM_DELAY_CALC_STATS_EN
    logic [15:0] r_row_hits;
    logic [15:0] r_row_misses;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_row_hits   <= '0;
            r_row_misses <= '0;
        end else if (r_state == DC_IDLE && !w_empty) begin
            if (w_row_hit) begin
                if (r_row_hits != 16'hFFFF) r_row_hits <= r_row_hits + 16'd1;
            end else begin
                if (r_row_misses != 16'hFFFF) r_row_misses <= r_row_misses + 16'd1;
            end
        end
    end

    assign row_hits_o   = r_row_hits;
    assign row_misses_o = r_row_misses;
`endif

    iid_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (waddr_valid_i && waddr_ready_o) |-> (int'(waddr_iid_i) < BankCapa));

    release_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(release_en_o));

endmodule

// File: tb/tb_simmem_wrsp_delay_calc.sv
// Bench for simmem_wrsp_delay_calc: directed scenarios plus random traffic against a
// per-request timing model (accept, load and release edges).
module tb_simmem_wrsp_delay_calc;
    import simmem_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    waddr_t                   waddr_i;
    logic [WRspBankAddrW-1:0] waddr_iid_i;
    logic                     waddr_valid_i;
    logic                     waddr_ready_o;
    logic [WRspBankCapa-1:0]  release_en_o;
    logic                     busy_o;
`ifdef SIMMEM_DELAY_CALC_STATS_EN
    logic [15:0]              row_hits_o;
    logic [15:0]              row_misses_o;
`endif

    simmem_wrsp_delay_calc dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .waddr_i       (waddr_i),
        .waddr_iid_i   (waddr_iid_i),
        .waddr_valid_i (waddr_valid_i),
        .waddr_ready_o (waddr_ready_o),
        .release_en_o  (release_en_o),
        .busy_o        (busy_o)
`ifdef SIMMEM_DELAY_CALC_STATS_EN
        ,
        .row_hits_o    (row_hits_o),
        .row_misses_o  (row_misses_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    localparam int MaxReq  = 1024;
    localparam int MaxCost = (1 << DelayW) - 1;

    int n_checks = 0;
    int n_errs   = 0;
    int edge_no  = 0;

    // One record per accepted request: edge of accept, of head load, of release pulse.
    int m_acc  [MaxReq];
    int m_load [MaxReq];
    int m_rel  [MaxReq];
    int m_iid  [MaxReq];
    bit m_hit  [MaxReq];
    int m_n;
    bit m_row_valid;
    int m_open_row;
    int m_prev_rel;
    int obs_edge [WRspBankCapa];
    bit accepted;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, edge_no);
        end
    endtask

    function automatic int occ(input int e);
        int o = 0;
        for (int i = 0; i < m_n; i++) begin
            if (m_acc[i] <= e)  o++;
            if (m_load[i] <= e) o--;
        end
        return o;
    endfunction

    task automatic model_clear();
        m_n         = 0;
        m_row_valid = 1'b0;
        m_open_row  = 0;
        m_prev_rel  = -1000;
    endtask

    task automatic model_accept();
        int row, len, rc, cost, load;
        row = int'(waddr_i.addr) >> (AxAddrWidth - RowIdWidth);
        len = 1 << int'(waddr_i.burst_len);
        if (!m_row_valid)            rc = ActivationCost + RowHitCost;
        else if (row == m_open_row)  rc = RowHitCost;
        else                         rc = PrechargeCost + ActivationCost + RowHitCost;
        cost = rc + len - 1;
        if (cost > MaxCost) cost = MaxCost;
        load = (edge_no + 1 > m_prev_rel + 1) ? edge_no + 1 : m_prev_rel + 1;
        if (m_n < MaxReq) begin
            m_acc[m_n]  = edge_no;
            m_load[m_n] = load;
            m_rel[m_n]  = load + cost;
            m_iid[m_n]  = int'(waddr_iid_i);
            m_hit[m_n]  = m_row_valid && (row == m_open_row);
            m_n++;
        end
        m_prev_rel  = load + cost;
        m_row_valid = 1'b1;
        m_open_row  = row;
    endtask

    task automatic check_cycle();
        int want_rel  = 0;
        int want_busy = 0;
        int want_hits = 0;
        int want_miss = 0;
        for (int i = 0; i < m_n; i++) begin
            if (m_rel[i] == edge_no) want_rel |= (1 << m_iid[i]);
            if (m_acc[i] <= edge_no && m_rel[i] > edge_no) want_busy = 1;
            if (m_load[i] <= edge_no) begin
                if (m_hit[i]) want_hits++;
                else          want_miss++;
            end
        end
        chk("release_en", int'(release_en_o), want_rel);
        chk("ready", int'(waddr_ready_o), (occ(edge_no) < NumWSlots) ? 1 : 0);
        chk("busy", int'(busy_o), want_busy);
`ifdef SIMMEM_DELAY_CALC_STATS_EN
        chk("row_hits", int'(row_hits_o), (want_hits > 65535) ? 65535 : want_hits);
        chk("row_misses", int'(row_misses_o), (want_miss > 65535) ? 65535 : want_miss);
`endif
        for (int b = 0; b < WRspBankCapa; b++)
            if (release_en_o[b]) obs_edge[b] = edge_no;
    endtask

    task automatic step();
        @(posedge clk_i);
        edge_no++;
        accepted = 1'b0;
        if (!rst_i && waddr_valid_i && (occ(edge_no - 1) < NumWSlots)) begin
            model_accept();
            accepted = 1'b1;
        end
        @(negedge clk_i);
        check_cycle();
    endtask

    task automatic drive(input int addr, input int len, input int iid);
        waddr_i           = '0;
        waddr_i.addr      = AxAddrWidth'(addr);
        waddr_i.burst_len = AxLenWidth'(len);
        waddr_i.id        = AxIdWidth'($urandom);
        waddr_iid_i       = WRspBankAddrW'(iid);
        waddr_valid_i     = 1'b1;
    endtask

    task automatic send(input int addr, input int len, input int iid, output int acc_edge);
        int budget = 400;
        drive(addr, len, iid);
        acc_edge = -1;
        while (budget > 0) begin
            step();
            budget--;
            if (accepted) begin
                acc_edge = edge_no;
                break;
            end
        end
        if (acc_edge < 0) chk("accept_timeout", 0, 1);
        waddr_valid_i = 1'b0;
    endtask

    task automatic drain(input int limit);
        int budget = limit;
        waddr_valid_i = 1'b0;
        while (budget > 0 && m_n > 0 && m_prev_rel >= edge_no) begin
            step();
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int a1, a2, a3, a_fresh, tmp;
        waddr_i       = '0;
        waddr_iid_i   = '0;
        waddr_valid_i = 1'b0;
        for (int b = 0; b < WRspBankCapa; b++) obs_edge[b] = -1;
        model_clear();

        repeat (3) step();
        chk("reset_ready", int'(waddr_ready_o), 1);
        chk("reset_release", int'(release_en_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        rst_i = 1'b0;
        repeat (2) step();

        // First access, same-row hit, then a row miss with a longer burst.
        send(32'h00400, 0, 3, a1);
        send(32'h00410, 0, 5, a2);
        send(32'h40000, 2, 1, a3);
        repeat (40) step();
        chk("first_latency", obs_edge[3] - a1, 6);
        chk("hit_gap", obs_edge[5] - obs_edge[3], 5);
        chk("miss_gap", obs_edge[1] - obs_edge[5], 11);

        // Fill the queue behind a long burst, then push one more across the wrap.
        send(32'h00800, 5, 7, tmp);
        for (int k = 0; k < 6; k++) send(32'h00800 + k * 4, 0, k, tmp);
        chk("fill_ready_low", int'(waddr_ready_o), 0);
        chk("fill_busy", int'(busy_o), 1);
        send(32'h00820, 0, 6, tmp);
        chk("refill_ready_low", int'(waddr_ready_o), 0);
        drain(400);
        for (int k = 0; k < 6; k++)
            chk("fifo_order", (obs_edge[k] < obs_edge[k + 1]) ? 1 : 0, 1);

        // Asynchronous reset while servicing with three requests queued.
        send(32'h0C000, 6, 4, tmp);
        send(32'h0C004, 0, 0, tmp);
        send(32'h10000, 1, 6, tmp);
        send(32'h0C008, 0, 2, tmp);
        repeat (3) step();
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_ready", int'(waddr_ready_o), 1);
        chk("async_rst_release", int'(release_en_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        model_clear();
        repeat (2) step();
        rst_i = 1'b0;
        repeat (5) step();
        send(32'h00400, 0, 2, a_fresh);
        repeat (10) step();
        chk("post_rst_latency", obs_edge[2] - a_fresh, 6);

        // Random traffic over a few rows, with occasional saturating bursts.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2) == 0) begin
                drive((int'($urandom_range(3)) << 10) | int'($urandom_range(1023)),
                      ($urandom_range(15) == 0) ? 7 : int'($urandom_range(3)),
                      int'($urandom_range(WRspBankCapa - 1)));
            end else begin
                waddr_valid_i = 1'b0;
            end
            step();
        end
        drain(3000);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
